// File: rtl/butterfly_pkg.sv
// ---------------------------------------------------------------------------
// butterfly_pkg
// Shared types and constants for the butterfly data-memory responder.
//   XLEN            : data / address width of the dmem bus
//   dmem_state_e    : responder FSM states (IDLE, WAIT, RESP)
//   DMEM_LFSR_SEED  : reset value of the optional random-stall LFSR
//   DMEM_LFSR_TAPS  : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
//   lfsr_next()     : one step of the 16-bit Fibonacci LFSR
// ---------------------------------------------------------------------------
package butterfly_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   localparam logic [15:0] DMEM_LFSR_SEED = 16'hACE1;
   localparam logic [15:0] DMEM_LFSR_TAPS = 16'hB400;

   // Shift left, feeding the XOR of the tapped bits into bit 0.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & DMEM_LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/butterfly_dmem_responder_if.sv
// ---------------------------------------------------------------------------
// butterfly_dmem_responder_if
// Core data-memory bus between an initiator (master) and the responder
// (slave).
//   dmem_valid_i/we_i/addr_i/wdata_i/wstrb_i : request, driven by master
//   dmem_rdata_o/ready_o/err_o               : response, driven by slave
//   busy_o                                   : responder not idle
// ---------------------------------------------------------------------------
interface butterfly_dmem_responder_if;
   import butterfly_pkg::*;

   logic              dmem_valid_i;
   logic              dmem_we_i;
   logic [XLEN-1:0]   dmem_addr_i;
   logic [XLEN-1:0]   dmem_wdata_i;
   logic [3:0]        dmem_wstrb_i;
   logic [XLEN-1:0]   dmem_rdata_o;
   logic              dmem_ready_o;
   logic              dmem_err_o;
   logic              busy_o;

   modport master (
      output dmem_valid_i, dmem_we_i, dmem_addr_i, dmem_wdata_i, dmem_wstrb_i,
      input  dmem_rdata_o, dmem_ready_o, dmem_err_o, busy_o
   );

   modport slave (
      input  dmem_valid_i, dmem_we_i, dmem_addr_i, dmem_wdata_i, dmem_wstrb_i,
      output dmem_rdata_o, dmem_ready_o, dmem_err_o, busy_o
   );

endinterface

// File: rtl/butterfly_sram_be.sv
// ---------------------------------------------------------------------------
// butterfly_sram_be
// Synchronous single-port word RAM with per-byte write enables and a
// registered read port. The read register only updates when re is high,
// so it holds the last word read in between.
//   clk   : clock
//   we    : write enable (bytes selected by be)
//   be    : byte enables, bit n covers wdata[8n+7:8n]
//   re    : read enable, loads rdata from mem[addr]
//   addr  : word index
//   wdata : write data
//   rdata : registered read data
// ---------------------------------------------------------------------------
module butterfly_sram_be
   import butterfly_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [3:0]                     be,
   input  logic                           re,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [XLEN-1:0]                wdata,
   output logic [XLEN-1:0]                rdata
);

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/butterfly_dmem_responder.sv
// ---------------------------------------------------------------------------
// butterfly_dmem_responder
// Responder end of the core data-memory interface: byte-writable word RAM
// with a fixed, programmable access latency and one request in flight.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset (RAM contents are kept)
//   dmem   : slave side of butterfly_dmem_responder_if
// Parameters:
//   DEPTH_WORDS : RAM size in 32-bit words (power of two, >= 4)
//   LATENCY     : wait cycles between acceptance and response (0..15)
// Optional build macro:
//   BUTTERFLY_DMEM_RAND_STALL_EN : adds 0..3 pseudo-random extra wait
//   cycles per request from a free-running 16-bit LFSR.
// ---------------------------------------------------------------------------
module butterfly_dmem_responder
   import butterfly_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   butterfly_dmem_responder_if.slave dmem
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = 5;   // holds LATENCY + 3 extra stall cycles

   dmem_state_e        state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [CW-1:0]      load_cnt;
   logic               enter_resp;

   logic               we_q;
   logic [XLEN-1:2]    addr_q;
   logic [XLEN-1:0]    wdata_q;
   logic [3:0]         wstrb_q;

   logic               req_we;
   logic [XLEN-1:2]    req_addr;
   logic [XLEN-1:0]    req_wdata;
   logic [3:0]         req_wstrb;
   logic               req_oor;

   logic               err_q;
   logic               rdata_zero_q;
   logic               ram_we, ram_re;
   logic [XLEN-1:0]    ram_rdata;

   logic               unused_addr_bits;
   assign unused_addr_bits = ^dmem.dmem_addr_i[1:0];

`ifdef BUTTERFLY_DMEM_RAND_STALL_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) lfsr_q <= DMEM_LFSR_SEED;
      else       lfsr_q <= lfsr_next(lfsr_q);
   end

   assign load_cnt = CW'(LATENCY) + CW'(lfsr_q[1:0]);
`else
   assign load_cnt = CW'(LATENCY);
`endif

   // With zero wait the RAM is accessed on the acceptance edge itself,
   // before the request has been latched, so IDLE uses the live bus.
   always_comb begin
      if (state_q == IDLE) begin
         req_we    = dmem.dmem_we_i;
         req_addr  = dmem.dmem_addr_i[XLEN-1:2];
         req_wdata = dmem.dmem_wdata_i;
         req_wstrb = dmem.dmem_wstrb_i;
      end else begin
         req_we    = we_q;
         req_addr  = addr_q;
         req_wdata = wdata_q;
         req_wstrb = wstrb_q;
      end
   end

   assign req_oor = |req_addr[XLEN-1:AW+2];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (dmem.dmem_valid_i) begin
               if (load_cnt == '0) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = load_cnt;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CW'(1)) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         rdata_zero_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (enter_resp) begin
            err_q <= req_oor;
            if (!req_we) rdata_zero_q <= req_oor;
         end
      end
   end

   // Request capture; data only, no reset needed.
   always_ff @(posedge clk_i) begin
      if (state_q == IDLE && dmem.dmem_valid_i) begin
         we_q    <= dmem.dmem_we_i;
         addr_q  <= dmem.dmem_addr_i[XLEN-1:2];
         wdata_q <= dmem.dmem_wdata_i;
         wstrb_q <= dmem.dmem_wstrb_i;
      end
   end

   // Reset on the RESP-entry edge must also abort the pending write.
   assign ram_we = enter_resp &&  req_we && !req_oor && !rst_i;
   assign ram_re = enter_resp && !req_we && !req_oor && !rst_i;

   butterfly_sram_be #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_sram (
      .clk   (clk_i),
      .we    (ram_we),
      .be    (req_wstrb),
      .re    (ram_re),
      .addr  (req_addr[AW+1:2]),
      .wdata (req_wdata),
      .rdata (ram_rdata)
   );

   assign dmem.dmem_ready_o = (state_q == RESP);
   assign dmem.dmem_err_o   = (state_q == RESP) && err_q;
   assign dmem.dmem_rdata_o = rdata_zero_q ? '0 : ram_rdata;
   assign dmem.busy_o       = (state_q != IDLE);

endmodule

// File: doc/butterfly_dmem_responder.md
Name: butterfly_dmem_responder

Overview:
Responder end of the core's data-memory interface (dmem_valid/we/addr/wdata/wstrb out, dmem_rdata/ready in). Word-organised, byte-writable on-chip data RAM with a programmable fixed access latency. One outstanding request at a time. Used as the dmem model in core-level simulation and as the FPGA data RAM.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 4
LATENCY, 1, wait cycles between request acceptance and response; 0..15

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
dmem_valid_i  input  1  request valid; level, held by initiator until ready
dmem_we_i  input  1  1 = write, 0 = read
dmem_addr_i  input  32  byte address; bits [1:0] ignored
dmem_wdata_i  input  32  write data
dmem_wstrb_i  input  4  byte enables; bit n writes wdata[8n+7:8n]
dmem_rdata_o  output  32  read data; valid only while dmem_ready_o=1 on a read
dmem_ready_o  output  1  one-cycle completion pulse
dmem_err_o  output  1  out-of-range flag; valid only with dmem_ready_o
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_i high at a clock edge): state=IDLE, dmem_ready_o=0, dmem_err_o=0, dmem_rdata_o=0, wait counter=0. RAM contents are not cleared.
- Word index = dmem_addr_i[log2(DEPTH_WORDS)+1:2]. Out of range if any of addr[31:log2(DEPTH_WORDS)+2] is nonzero.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If dmem_valid_i=1, latch we/addr/wdata/wstrb and load counter=LATENCY.
  - Go to WAIT if LATENCY>0. Otherwise go directly to RESP.
- WAIT:
  - Decrement counter each cycle.
  - Go to RESP at the edge where the counter reads 1.
  - Live inputs are ignored; latched values are used. If valid drops mid-request (protocol violation), the access still completes.
- Entry to RESP, on the same edge ready rises:
  - Write: update bytes selected by latched wstrb. wstrb=0000 changes nothing but still completes.
  - Read: register the RAM word into dmem_rdata_o.
  - Out of range: write suppressed, rdata=0, err=1.
- RESP: dmem_ready_o=1 for exactly this one cycle. Next state is IDLE unconditionally.
- Timing:
  - Request sampled at edge T. Ready is high during cycle T+1+LATENCY.
  - Minimum request-to-request spacing is LATENCY+2 cycles.
  - A write is visible to the next read.
- In IDLE and WAIT: dmem_rdata_o holds its last value, and ready=0, err=0.
- Reset during WAIT or RESP: aborts to IDLE. A pending write is not committed if reset precedes the RESP-entry edge.

Optional Feature:
BUTTERFLY_DMEM_RAND_STALL_EN
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset, advancing every cycle.
  - At request acceptance, counter = LATENCY + lfsr[1:0], adding 0..3 extra wait cycles.
  - With LATENCY=0 and lfsr[1:0]≠0, the FSM goes to WAIT.
- Undefined: latency is fixed; no LFSR logic is present.

Decomposition:
- butterfly_pkg gains:
  - dmem_state_e (IDLE/WAIT/RESP)
  - DMEM_LFSR_SEED and DMEM_LFSR_TAPS constants
  - XLEN=32
- Sub-module butterfly_sram_be: synchronous single-port RAM with a 4-bit byte-write enable and registered read, DEPTH_WORDS parameter. The responder instantiates one.

Test Plan:
All scenarios use LATENCY=2, DEPTH_WORDS=1024, macro undefined unless stated.
1. rst_i high 3 cycles -> ready=0, err=0, rdata=0, busy=0.
2. Write addr=0x10, wdata=0xDEADBEEF, wstrb=1111 sampled at T -> ready at T+3, err=0. Then read 0x10 -> rdata=0xDEADBEEF with ready.
3. Write 0x10, wdata=0x0000AA00, wstrb=0010 -> read 0x10 returns 0xDEADAAEF. Write with wstrb=0000 -> value unchanged.
4. Read 0x00001000 -> ready with err=1, rdata=0. Write 0x11223344 to 0x00001000 -> err=1, and read 0x0 is unchanged.
5. valid held high for back-to-back reads of 0x10 then 0x14 -> ready pulses 4 cycles apart; each pulse is exactly 1 cycle.
6. Write 0x55 to 0x20, rst_i pulsed during WAIT -> no ready; read 0x20 returns the prior value. With the macro defined, 100 random reads -> every request-to-ready latency is in 3..6 cycles and all data is correct.
